// File: rtl/iecdrv_head_track.sv
// Head position and track-cache manager for the IEC drive family.
// Decodes stepper phases into a half-track position, applies side offset,
// generates disk-change write-protect blinking, holds the drive in reset
// after a model change and issues dirty-track flush requests to the loader.
module iecdrv_head_track #(
    parameter int MAX_HTRACK  = 84,
    parameter int SIDE_OFFSET = 84,
    parameter int INIT_HTRACK = 36,
    parameter int WPS_W       = 24,
    parameter int HOLD_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       ph2_r,
    input  logic [1:0] drv_mode,
    input  logic       img_mounted,
    input  logic       img_readonly,
    input  logic       img_present,
    input  logic [1:0] stp,
    input  logic       mtr,
    input  logic       act,
    input  logic       side,
    input  logic       we,
    input  logic       save_ack,
    output logic       reset_drv,
    output logic [7:0] track,
    output logic       tr00_sense_n,
    output logic       wps_n,
    output logic       disk_present,
    output logic       save_req,
    output logic [7:0] save_track,
    output logic       save_overrun
);

    localparam logic [7:0] MAX_H  = 8'(MAX_HTRACK);
    localparam logic [7:0] SIDE_O = 8'(SIDE_OFFSET);
    localparam logic [7:0] INIT_H = 8'(INIT_HTRACK);
    localparam logic [7:0] HOLD_N = 8'(HOLD_CYCLES);

    logic [1:0]       last_mode;
    logic [7:0]       hold;
    logic             chg;
    logic [7:0]       htrack;
    logic [7:0]       htrack_nxt;
    logic [1:0]       stp_old;
    logic [1:0]       d;
    logic             side_old;
    logic             accepted;
    logic             side_chg;
    logic             trigger;
    logic             mnt_old;
    logic             mnt_edge;
    logic             readonly;
    logic [WPS_W-1:0] timer;
    logic             dirty;
    logic             pending;
    logic [7:0]       pending_track;
    logic             dirty_nxt;
    logic             req_nxt;
    logic             pend_nxt;
    logic [7:0]       strk_nxt;
    logic [7:0]       ptrk_nxt;
    logic             ovr_nxt;

    assign reset_drv = reset | chg;
    assign d         = stp - stp_old;
    assign side_chg  = side ^ side_old;
    assign mnt_edge  = img_mounted & ~mnt_old;
    assign accepted  = (htrack_nxt != htrack);
    assign trigger   = dirty & (accepted | (mtr & side_chg) | ~act);
    assign wps_n     = ~readonly ^ timer[WPS_W-2];

    // Mode-change hold: keeps the drive in reset for HOLD_CYCLES+1 strobes.
    // Uses the external reset only, so it can release its own hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_mode <= drv_mode;
            hold      <= 8'd0;
            chg       <= 1'b0;
        end else if (ph2_r) begin
            last_mode <= drv_mode;
            if (drv_mode != last_mode) begin
                hold <= HOLD_N;
                chg  <= 1'b1;
            end else if (hold != 8'd0) begin
                hold <= hold - 8'd1;
            end else begin
                chg <= 1'b0;
            end
        end
    end

    // Edge-detect history; free-running so nothing is lost across a reset.
    always_ff @(posedge clk) begin
        stp_old  <= stp;
        side_old <= side;
        mnt_old  <= img_mounted;
    end

    // Stepper decode: phase delta of +1/-1 moves the head, saturating at the ends.
    always_comb begin
        htrack_nxt = htrack;
        if (mtr) begin
            if (d == 2'd1 && htrack < MAX_H)
                htrack_nxt = htrack + 8'd1;
            else if (d == 2'd3 && htrack != 8'd0)
                htrack_nxt = htrack - 8'd1;
        end
    end

    // Head position and the registered track/track-0 outputs derived from it.
    always_ff @(posedge clk) begin
        if (reset_drv) begin
            htrack       <= INIT_H;
            track        <= INIT_H;
            tr00_sense_n <= (INIT_H != 8'd0);
        end else begin
            htrack       <= htrack_nxt;
            track        <= htrack + (side ? SIDE_O : 8'd0);
            tr00_sense_n <= (htrack != 8'd0);
        end
    end

    // Flush slots: ack frees a slot first, then a trigger fills the first free one.
    // The track register still holds the track being left when a trigger fires.
    always_comb begin
        dirty_nxt = dirty;
        req_nxt   = save_req;
        pend_nxt  = pending;
        strk_nxt  = save_track;
        ptrk_nxt  = pending_track;
        ovr_nxt   = save_overrun;
        if (save_ack && save_req) begin
            if (pending) begin
                strk_nxt = pending_track;
                pend_nxt = 1'b0;
            end else begin
                req_nxt = 1'b0;
            end
        end
        if (trigger) begin
            dirty_nxt = 1'b0;
            if (!req_nxt) begin
                req_nxt  = 1'b1;
                strk_nxt = track;
            end else if (!pend_nxt) begin
                pend_nxt = 1'b1;
                ptrk_nxt = track;
            end else begin
                ovr_nxt = 1'b1;
            end
        end
        if (we)
            dirty_nxt = 1'b1;
        if (mnt_edge) begin
            dirty_nxt = 1'b0;
            req_nxt   = 1'b0;
            pend_nxt  = 1'b0;
        end
    end

    // Flush state registers.
    always_ff @(posedge clk) begin
        if (reset_drv) begin
            dirty         <= 1'b0;
            save_req      <= 1'b0;
            pending       <= 1'b0;
            save_track    <= 8'd0;
            pending_track <= 8'd0;
            save_overrun  <= 1'b0;
        end else begin
            dirty         <= dirty_nxt;
            save_req      <= req_nxt;
            pending       <= pend_nxt;
            save_track    <= strk_nxt;
            pending_track <= ptrk_nxt;
            save_overrun  <= ovr_nxt;
        end
    end

    // Disk-change state survives drive resets; the timer makes wps_n blink
    // after a mount so the drive ROM notices the new disk.
    always_ff @(posedge clk) begin
        if (mnt_edge) begin
            timer        <= '1;
            readonly     <= img_readonly;
            disk_present <= img_present;
        end else if (ce && timer != '0) begin
            timer <= timer - WPS_W'(1);
        end
    end

endmodule
